// File: rtl/fir_output_stage.sv
// Output stage for the 16-tap FIR: rounding shift, saturation, decimation and a FWFT FIFO.
// Optional pushed-sample counter on o_SampleCount is built only when FIR_OUT_STATS_EN is defined.
module fir_output_stage #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     areset_n,
  input  logic                     en_FIR,
  input  logic [IN_W-1:0]          i_Data,
  input  logic [5:0]               i_Shift,
  input  logic [4:0]               i_Decim,
  input  logic                     i_Clear,
  output logic [OUT_W-1:0]         o_Data,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [$clog2(DEPTH):0]   o_Level,
  output logic                     o_Sat,
  output logic                     o_Drop,
  output logic [31:0]              o_SampleCount
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [4:0]      decim_eff;
  logic [IN_W:0]   rnd_add;
  logic [IN_W:0]   sum_full;
  logic [IN_W:0]   shifted;
  logic            sat_now;
  logic [OUT_W-1:0] sat_val;
  logic            keep_now;

  logic [4:0]       cnt_reg;
  logic             s1_keep_reg;
  logic             s1_sat_reg;
  logic [OUT_W-1:0] s1_data_reg;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [OUT_W-1:0] head_reg;
  logic             sat_reg;
  logic             drop_reg;

  logic push, pop, full, wr_ok;

  always_comb begin
    decim_eff = i_Decim;
    if (i_Decim == 5'd0)
      decim_eff = 5'd1;
    else if (i_Decim > 5'd16)
      decim_eff = 5'd16;
  end

  // One extra bit keeps the rounding carry of an all-ones input.
  assign rnd_add  = (i_Shift == 6'd0) ? '0 : ((IN_W+1)'(1) << (i_Shift - 6'd1));
  assign sum_full = {1'b0, i_Data} + rnd_add;
  assign shifted  = sum_full >> i_Shift;
  assign sat_now  = |shifted[IN_W:OUT_W];
  assign sat_val  = sat_now ? '1 : shifted[OUT_W-1:0];
  // ">=" rather than "==" so a runtime decrease of i_Decim keeps immediately.
  assign keep_now = (cnt_reg >= (decim_eff - 5'd1));

  always_ff @(posedge CLK or negedge areset_n) begin
    if (!areset_n) begin
      cnt_reg     <= '0;
      s1_keep_reg <= 1'b0;
      s1_sat_reg  <= 1'b0;
      s1_data_reg <= '0;
    end else if (i_Clear) begin
      cnt_reg     <= '0;
      s1_keep_reg <= 1'b0;
      s1_sat_reg  <= 1'b0;
    end else begin
      s1_keep_reg <= en_FIR & keep_now;
      if (en_FIR) begin
        cnt_reg     <= keep_now ? 5'd0 : cnt_reg + 5'd1;
        s1_sat_reg  <= sat_now;
        s1_data_reg <= sat_val;
      end
    end
  end

  assign push  = s1_keep_reg;
  assign pop   = (level_reg != '0) & i_Ready;
  assign full  = (level_reg == LVL_FULL);
  assign wr_ok = push & (~full | pop);

  always_ff @(posedge CLK) begin
    if (wr_ok && !i_Clear)
      mem[wr_ptr_reg] <= s1_data_reg;
  end

  always_ff @(posedge CLK or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
      sat_reg    <= 1'b0;
      drop_reg   <= 1'b0;
    end else if (i_Clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      sat_reg    <= 1'b0;
      drop_reg   <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_ok, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
      // Head register gives fall-through output and holds the last value when empty.
      if (pop && level_reg > LVL_ONE)
        head_reg <= mem[rd_ptr_reg + AW'(1)];
      else if (wr_ok && (level_reg == '0 || pop))
        head_reg <= s1_data_reg;
      if (push && s1_sat_reg)
        sat_reg <= 1'b1;
      if (push && full && !pop)
        drop_reg <= 1'b1;
    end
  end

  assign o_Data  = head_reg;
  assign o_Valid = (level_reg != '0);
  assign o_Level = level_reg;
  assign o_Sat   = sat_reg;
  assign o_Drop  = drop_reg;

`ifdef FIR_OUT_STATS_EN
  logic [31:0] count_reg;
  always_ff @(posedge CLK or negedge areset_n) begin
    if (!areset_n)
      count_reg <= '0;
    else if (i_Clear)
      count_reg <= '0;
    else if (wr_ok)
      count_reg <= count_reg + 32'd1;
  end
  assign o_SampleCount = count_reg;
`else
  assign o_SampleCount = '0;
`endif

endmodule

// File: tb/tb_fir_output_stage.sv
// Self-checking bench for fir_output_stage: directed plan steps followed by random traffic,
// all compared against a queue-based reference model after every clock edge.
module tb_fir_output_stage;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        areset_n = 1'b0;
  logic        en_FIR = 1'b0;
  logic [63:0] i_Data = '0;
  logic [5:0]  i_Shift = '0;
  logic [4:0]  i_Decim = 5'd1;
  logic        i_Clear = 1'b0;
  logic        i_Ready = 1'b0;
  logic [31:0] o_Data;
  logic        o_Valid;
  logic [3:0]  o_Level;
  logic        o_Sat;
  logic        o_Drop;
  logic [31:0] o_SampleCount;

  int checks = 0;
  int errors = 0;

  fir_output_stage #(.IN_W(64), .OUT_W(32), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .areset_n(areset_n), .en_FIR(en_FIR), .i_Data(i_Data),
    .i_Shift(i_Shift), .i_Decim(i_Decim), .i_Clear(i_Clear), .o_Data(o_Data),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Level(o_Level), .o_Sat(o_Sat),
    .o_Drop(o_Drop), .o_SampleCount(o_SampleCount)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_pend_v;
  logic [31:0] m_pend_data;
  bit          m_pend_sat;
  int          m_since_keep;
  bit          m_sat, m_drop;
  logic [31:0] m_cnt;
  logic [31:0] m_head;

  task automatic model_reset(input bit keep_head);
    m_q.delete();
    m_pend_v = 0; m_since_keep = 0; m_sat = 0; m_drop = 0; m_cnt = '0;
    if (!keep_head) m_head = '0;
  endtask

  // Round half up: floor(d / 2^sh) plus the bit just below the cut.
  function automatic logic [64:0] round_div(input logic [63:0] d, input logic [5:0] sh);
    logic [64:0] q;
    q = {1'b0, d} >> sh;
    if (sh != 0 && d[sh-1]) q = q + 65'd1;
    return q;
  endfunction

  task automatic model_edge(input bit en, input logic [63:0] d, input logic [5:0] sh,
                            input logic [4:0] dc, input bit rdy, input bit clr);
    int eff;
    logic [64:0] r;
    if (clr) begin
      model_reset(1);
      return;
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (m_pend_v) begin
      if (m_pend_sat) m_sat = 1;
      if (m_q.size() < DEPTH) begin
        m_q.push_back(m_pend_data);
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_drop = 1;
      end
    end
    m_pend_v = 0;
    if (en) begin
      eff = (dc == 0) ? 1 : ((dc > 16) ? 16 : int'(dc));
      if (m_since_keep + 1 >= eff) begin
        r = round_div(d, sh);
        m_pend_v    = 1;
        m_pend_sat  = (r > 65'h0_FFFF_FFFF);
        m_pend_data = m_pend_sat ? 32'hFFFF_FFFF : r[31:0];
        m_since_keep = 0;
      end else begin
        m_since_keep++;
      end
    end
    if (m_q.size() > 0) m_head = m_q[0];
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(o_Valid), 64'(m_q.size() > 0));
    check({tag, ".level"}, 64'(o_Level), 64'(m_q.size()));
    check({tag, ".data"},  64'(o_Data),  64'(m_head));
    check({tag, ".sat"},   64'(o_Sat),   64'(m_sat));
    check({tag, ".drop"},  64'(o_Drop),  64'(m_drop));
`ifdef FIR_OUT_STATS_EN
    check({tag, ".count"}, 64'(o_SampleCount), 64'(m_cnt));
`else
    check({tag, ".count"}, 64'(o_SampleCount), 64'd0);
`endif
  endtask

  task automatic step(input string tag, input bit en, input logic [63:0] d, input logic [5:0] sh,
                      input logic [4:0] dc, input bit rdy, input bit clr);
    en_FIR = en; i_Data = d; i_Shift = sh; i_Decim = dc; i_Ready = rdy; i_Clear = clr;
    @(posedge CLK);
    model_edge(en, d, sh, dc, rdy, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [63:0] rd;
    logic [5:0]  rs;
    logic [4:0]  rdc;
    model_reset(0);

    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    areset_n = 1'b1;

    // Rounding: 0x180>>8 rounds up to 2, 0x17F>>8 rounds to 1
    step("rnd_in0", 1, 64'h180, 6'd8, 5'd1, 0, 0);
    check("rnd_notyet", 64'(o_Valid), 64'd0);
    step("rnd_in1", 1, 64'h17F, 6'd8, 5'd1, 0, 0);
    check("rnd_first", 64'(o_Data), 64'h2);
    step("rnd_hold", 0, 64'h0, 6'd8, 5'd1, 0, 0);
    check("rnd_hold_data", 64'(o_Data), 64'h2);
    step("rnd_pop", 0, 64'h0, 6'd8, 5'd1, 1, 0);
    check("rnd_second", 64'(o_Data), 64'h1);
    repeat (2) step("rnd_drain", 0, 64'h0, 6'd8, 5'd1, 1, 0);

    // Saturation and sticky flag
    step("sat_in", 1, 64'hFFFF_FFFF_0000_0001, 6'd0, 5'd1, 1, 0);
    step("sat_wr", 0, 64'h0, 6'd0, 5'd1, 0, 0);
    check("sat_data", 64'(o_Data), 64'hFFFF_FFFF);
    check("sat_flag", 64'(o_Sat), 64'd1);
    repeat (3) step("sat_sticky", 0, 64'h0, 6'd0, 5'd1, 1, 0);
    step("sat_clear", 0, 64'h0, 6'd0, 5'd1, 0, 1);
    check("sat_cleared", 64'(o_Sat), 64'd0);

    // Decimation by 4, back-to-back and with gaps
    for (int i = 1; i <= 8; i++) step("dec_seq", 1, 64'(i), 6'd0, 5'd4, 1, 0);
    repeat (3) step("dec_tail", 0, 64'h0, 6'd0, 5'd4, 1, 0);
    check("dec_last", 64'(o_Data), 64'd8);
    for (int i = 1; i <= 8; i++) begin
      step("dec_gap_in", 1, 64'(i), 6'd0, 5'd4, 1, 0);
      step("dec_gap", 0, 64'h0, 6'd0, 5'd4, 1, 0);
    end
    repeat (2) step("dec_gtail", 0, 64'h0, 6'd0, 5'd4, 1, 0);

    // Overflow: ten pushes into an eight-deep FIFO, then drain
    step("ovf_clr", 0, 64'h0, 6'd0, 5'd1, 0, 1);
    for (int i = 1; i <= 10; i++) step("ovf_in", 1, 64'(i), 6'd0, 5'd1, 0, 0);
    step("ovf_settle", 0, 64'h0, 6'd0, 5'd1, 0, 0);
    check("ovf_level", 64'(o_Level), 64'd8);
    check("ovf_drop", 64'(o_Drop), 64'd1);
    for (int i = 1; i <= 9; i++) step("ovf_drain", 0, 64'h0, 6'd0, 5'd1, 1, 0);

    // Full FIFO with concurrent pop and push
    step("fp_clr", 0, 64'h0, 6'd0, 5'd1, 0, 1);
    for (int i = 1; i <= 8; i++) step("fp_fill", 1, 64'(i + 16), 6'd0, 5'd1, 0, 0);
    step("fp_full", 1, 64'h99, 6'd0, 5'd1, 0, 0);
    check("fp_is_full", 64'(o_Level), 64'd8);
    step("fp_both", 0, 64'h0, 6'd0, 5'd1, 1, 0);
    check("fp_level", 64'(o_Level), 64'd8);
    check("fp_nodrop", 64'(o_Drop), 64'd0);
    for (int i = 1; i <= 9; i++) step("fp_drain", 0, 64'h0, 6'd0, 5'd1, 1, 0);

    // Asynchronous reset with five entries buffered
    for (int i = 1; i <= 5; i++) step("rst_fill", 1, 64'(i * 3), 6'd0, 5'd1, 0, 0);
    step("rst_settle", 0, 64'h0, 6'd0, 5'd1, 0, 0);
    #2 areset_n = 1'b0;
    #1 model_reset(0);
    check_all("rst_async");
    #1 areset_n = 1'b1;
    step("rst_idle", 0, 64'h0, 6'd0, 5'd1, 1, 0);
    step("rst_in", 1, 64'h500, 6'd4, 5'd1, 0, 0);
    step("rst_out", 0, 64'h0, 6'd4, 5'd1, 0, 0);
    check("rst_new", 64'(o_Data), 64'h50);

    // Random traffic
    rs = 6'd0; rdc = 5'd1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) rdc = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) rs = 6'($urandom_range(0, 63));
      rd = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 2) != 0) rd = rd >> $urandom_range(0, 63);
      step("rand", $urandom_range(0, 3) != 0, rd, rs, rdc,
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
